firebird7_in_gate1_tessent_data_mux_ctrl_w3: RTL and testbench

FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CTRL_W3 -- requirements
Module: firebird7_in_gate1_tessent_data_mux_ctrl_w3

---
 rtl/firebird7_in_gate1_tessent_pkg.sv | 24 ++
 rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w3.sv | 189 ++++++++++++++++++
 tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w3.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_pkg.sv
// Shared types and constants for the IJTAG-controlled data-mux takeover logic.
// Holds the controller state encoding, the TDR bit layout and a counter sizing helper.
package firebird7_in_gate1_tessent_pkg;

    typedef enum logic [2:0] {
        ST_FUNC      = 3'd0,
        ST_REQ       = 3'd1,
        ST_GUARD_ON  = 3'd2,
        ST_TEST      = 3'd3,
        ST_GUARD_OFF = 3'd4
    } mux_ctrl_state_e;

    localparam int TDR_EN_BIT    = 0;
    localparam int TDR_FORCE_BIT = 1;
    localparam int TDR_DATA_LSB  = 2;

    // Bits needed for a counter that runs 0 .. max(guard, timeout)-1.
    function automatic int ctr_width(input int guard_cycles, input int timeout_cycles);
        int m;
        m = (guard_cycles > timeout_cycles) ? guard_cycles : timeout_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w3.sv
// IJTAG TDR plus takeover FSM that hands a functional data mux over to the test network,
// with guard intervals around every select change and a bounded wait for the grant.
module firebird7_in_gate1_tessent_data_mux_ctrl_w3
    import firebird7_in_gate1_tessent_pkg::*;
#(
    parameter int DATA_WIDTH     = 3,
    parameter int GUARD_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    input  logic                  ijtag_si,
    output logic                  ijtag_so,
    input  logic                  takeover_ack,
    output logic                  takeover_req,
    output logic                  ijtag_select,
    output logic [DATA_WIDTH-1:0] ijtag_data_out
);

    localparam int TDR_W = DATA_WIDTH + 2;
    localparam int CNT_W = ctr_width(GUARD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TDR_W-1:0]      tdr_q, tdr_d;
    logic                  en_u_q, en_u_d;
    logic                  force_u_q, force_u_d;
    logic [DATA_WIDTH-1:0] data_u_q, data_u_d;
    logic                  sticky_q, sticky_d;
    mux_ctrl_state_e       state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  select_q, select_d;
    logic                  req_q, req_d;
    logic                  upd;
    logic                  timeout_hit;

    assign upd            = ijtag_sel && ijtag_ue;
    assign ijtag_so       = tdr_q[0];
    assign ijtag_select   = select_q;
    assign takeover_req   = req_q;
    assign ijtag_data_out = data_u_q;

    // Capture wins over shift; update only looks at the current shift contents.
    always_comb begin
        tdr_d = tdr_q;
        if (ijtag_sel && ijtag_ce) begin
            tdr_d[TDR_EN_BIT]                = select_q;
            tdr_d[TDR_FORCE_BIT]             = sticky_q;
            tdr_d[TDR_W-1:TDR_DATA_LSB]      = data_u_q;
        end else if (ijtag_sel && ijtag_se) begin
            tdr_d = {ijtag_si, tdr_q[TDR_W-1:1]};
        end
    end

    always_comb begin
        en_u_d    = en_u_q;
        force_u_d = force_u_q;
        data_u_d  = data_u_q;
        if (upd) begin
            en_u_d    = tdr_q[TDR_EN_BIT];
            force_u_d = tdr_q[TDR_FORCE_BIT];
            data_u_d  = tdr_q[TDR_W-1:TDR_DATA_LSB];
        end
    end

    // A fresh enable clears the flag even if a timeout lands on the same edge.
    always_comb begin
        sticky_d = sticky_q;
        if (upd && tdr_q[TDR_EN_BIT]) begin
            sticky_d = 1'b0;
        end else if (timeout_hit) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            tdr_q     <= '0;
            en_u_q    <= 1'b0;
            force_u_q <= 1'b0;
            data_u_q  <= '0;
            sticky_q  <= 1'b0;
        end else begin
            tdr_q     <= tdr_d;
            en_u_q    <= en_u_d;
            force_u_q <= force_u_d;
            data_u_q  <= data_u_d;
            sticky_q  <= sticky_d;
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state_q <= ST_FUNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_FUNC: begin
                cnt_d = '0;
                if (en_u_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!en_u_q) begin
                    state_d = ST_FUNC;
                    cnt_d   = '0;
                end else if (takeover_ack || force_u_q) begin
                    state_d = ST_GUARD_ON;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_FUNC;
                    cnt_d       = '0;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GUARD_ON: begin
                if (!en_u_q) begin
                    state_d = ST_FUNC;
                    cnt_d   = '0;
                end else if (cnt_q == GUARD_LAST) begin
                    state_d = ST_TEST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TEST: begin
                cnt_d = '0;
                if (!en_u_q) begin
                    state_d = ST_GUARD_OFF;
                end
            end
            ST_GUARD_OFF: begin
                // Runs to completion regardless of en_u; a new enable is seen from FUNC.
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_FUNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_FUNC;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they toggle on the same edge as the state register.
    always_comb begin
        select_d = 1'b0;
        req_d    = 1'b0;
        case (state_d)
            ST_REQ, ST_GUARD_ON, ST_GUARD_OFF: req_d = 1'b1;
            ST_TEST: begin
                select_d = 1'b1;
                req_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            select_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            select_q <= select_d;
            req_q    <= req_d;
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w3.sv
// Directed and randomized bench for the data-mux takeover controller.
// Expected timelines are derived arithmetically from grant edge, guard length and timeout.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w3;

    localparam int DW = 3;
    localparam int G  = 4;
    localparam int T  = 15;
    localparam int N  = DW + 2;

    logic          ijtag_tck = 1'b0;
    logic          ijtag_reset = 1'b0;
    logic          ijtag_sel = 1'b0;
    logic          ijtag_ce = 1'b0;
    logic          ijtag_se = 1'b0;
    logic          ijtag_ue = 1'b0;
    logic          ijtag_si = 1'b0;
    logic          ijtag_so;
    logic          takeover_ack = 1'b0;
    logic          takeover_req;
    logic          ijtag_select;
    logic [DW-1:0] ijtag_data_out;

    int errors = 0;
    int checks = 0;

    firebird7_in_gate1_tessent_data_mux_ctrl_w3 #(
        .DATA_WIDTH    (DW),
        .GUARD_CYCLES  (G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .ijtag_tck     (ijtag_tck),
        .ijtag_reset   (ijtag_reset),
        .ijtag_sel     (ijtag_sel),
        .ijtag_ce      (ijtag_ce),
        .ijtag_se      (ijtag_se),
        .ijtag_ue      (ijtag_ue),
        .ijtag_si      (ijtag_si),
        .ijtag_so      (ijtag_so),
        .takeover_ack  (takeover_ack),
        .takeover_req  (takeover_req),
        .ijtag_select  (ijtag_select),
        .ijtag_data_out(ijtag_data_out)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge ijtag_tck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scan_load(input logic en, input logic fo, input logic [DW-1:0] d);
        logic [N-1:0] v;
        v = {d, fo, en};
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        for (int i = 0; i < N; i++) begin
            ijtag_si = v[i];
            step();
        end
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
        ijtag_ue = 1'b1;
        step();
        ijtag_ue  = 1'b0;
        ijtag_sel = 1'b0;
    endtask

    task automatic capture(output logic [N-1:0] v);
        v = '0;
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b1;
        step();
        ijtag_ce = 1'b0;
        ijtag_se = 1'b1;
        for (int i = 0; i < N; i++) begin
            v[i] = ijtag_so;
            if (i < N - 1) step();
        end
        ijtag_se  = 1'b0;
        ijtag_sel = 1'b0;
    endtask

    // ack_edge: first edge (counted from the update edge) where ack is held high; 0 = never.
    task automatic run_case(input string name, input logic [DW-1:0] d, input logic fo, input int ack_edge);
        bit           granted;
        int           g;
        logic [N-1:0] cap;
        granted = fo || (ack_edge != 0);
        g = (fo || ack_edge < 2) ? 2 : ack_edge;
        scan_load(1'b1, fo, d);
        chk($sformatf("%s/req_before", name), 32'(takeover_req), 32'd0);
        for (int k = 1; k <= 24; k++) begin
            takeover_ack = (ack_edge != 0) && (k >= ack_edge);
            step();
            chk($sformatf("%s/req@%0d", name, k), 32'(takeover_req),
                32'(granted ? 1'b1 : ((k % (T + 1)) != 0)));
            chk($sformatf("%s/sel@%0d", name, k), 32'(ijtag_select), 32'(granted && (k >= g + G)));
            chk($sformatf("%s/data@%0d", name, k), 32'(ijtag_data_out), 32'(d));
        end
        takeover_ack = 1'b0;
        capture(cap);
        chk($sformatf("%s/cap_en", name), 32'(cap[0]), 32'(granted));
        chk($sformatf("%s/cap_sticky", name), 32'(cap[1]), 32'(!granted));
        chk($sformatf("%s/cap_data", name), 32'(cap[N-1:2]), 32'(d));
        scan_load(1'b0, 1'b0, d);
        for (int k = 1; k <= G + 1; k++) begin
            step();
            if (granted) begin
                chk($sformatf("%s/off_sel@%0d", name, k), 32'(ijtag_select), 32'd0);
                chk($sformatf("%s/off_req@%0d", name, k), 32'(takeover_req), 32'(k <= G));
            end
        end
        repeat (2) step();
        chk($sformatf("%s/idle_req", name), 32'(takeover_req), 32'd0);
        chk($sformatf("%s/idle_sel", name), 32'(ijtag_select), 32'd0);
    endtask

    initial begin
        logic [N-1:0] cap;
        logic [DW-1:0] rd;
        logic          rf;
        int            ra;

        // Reset state
        step();
        chk("rst/req", 32'(takeover_req), 32'd0);
        chk("rst/sel", 32'(ijtag_select), 32'd0);
        chk("rst/data", 32'(ijtag_data_out), 32'd0);
        chk("rst/so", 32'(ijtag_so), 32'd0);
        step();
        ijtag_reset = 1'b1;
        repeat (2) step();
        chk("idle/req", 32'(takeover_req), 32'd0);

        // Directed scenarios: ack after 2, pure timeout, force, grant on the timeout edge
        run_case("s1_ack2", 3'b101, 1'b0, 2);
        run_case("s2_timeout", 3'b010, 1'b0, 0);
        run_case("s3_force", 3'b111, 1'b1, 0);
        run_case("s5_ack_at_timeout", 3'b011, 1'b0, T + 1);
        run_case("ack_early", 3'b100, 1'b0, 1);

        // Randomized cases
        for (int it = 0; it < 8; it++) begin
            rd = DW'($urandom_range(0, (1 << DW) - 1));
            rf = ($urandom_range(0, 3) == 0);
            ra = $urandom_range(0, T + 2);
            if (ra > T + 1) ra = 0;
            run_case($sformatf("rnd%0d", it), rd, rf, ra);
        end

        // Reset while in TEST
        scan_load(1'b1, 1'b1, 3'b110);
        repeat (8) step();
        chk("s6/sel_test", 32'(ijtag_select), 32'd1);
        chk("s6/req_test", 32'(takeover_req), 32'd1);
        #2;
        ijtag_reset = 1'b0;
        #1;
        chk("s6/sel_async", 32'(ijtag_select), 32'd0);
        chk("s6/req_async", 32'(takeover_req), 32'd0);
        chk("s6/data_async", 32'(ijtag_data_out), 32'd0);
        chk("s6/so_async", 32'(ijtag_so), 32'd0);
        step();
        #3;
        ijtag_reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("s6/func_req@%0d", k), 32'(takeover_req), 32'd0);
            chk($sformatf("s6/func_sel@%0d", k), 32'(ijtag_select), 32'd0);
        end
        capture(cap);
        chk("s6/cap_all", 32'(cap), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
